// File: rtl/retire_unit.sv
// retire_unit: in-order commit stage at the head of the reorder buffer.
//
// Each cycle the RETIRE_RATE oldest ROB entries (slot 0 = oldest) are examined
// and a zero-latency retire count is returned so the ROB can advance its read
// pointer in the same cycle. Stores commit via a Req/Ack handshake with the
// LSU. A faulting head entry raises a trap to the CSR unit; once acknowledged
// a single-cycle Flush is driven to the ROB and dispatch.
//
// Ports:
//   clk, rst          core clock, synchronous active-high reset
//   ROB_ReadData      head entries, slot 0 in the low ROB_LEN bits
//   ROB_UsedEntries   number of occupied ROB entries
//   Hold_Retire       suppress all retirement this cycle
//   RetireCnt         entries retired this cycle
//   Retire_Valid      per-slot retire strobe (thermometer code)
//   StoreCommit_Req   head-most eligible store asks the LSU to commit
//   StoreCommit_Ack   LSU accepts the store this cycle
//   Trap_Valid        trap pending to CSR unit
//   Trap_PC           PC of the faulting entry
//   Trap_Cause        exception cause of the faulting entry
//   Trap_Ack          CSR unit has taken the trap
//   Flush             one-cycle pipeline/ROB flush
//   InstRet           retired-instruction counter (wraps at 2^64)

`ifndef PC_LEN
`define PC_LEN 32
`endif
`ifndef ECAUSE_LEN
`define ECAUSE_LEN 5
`endif
`ifndef ROB_LEN
`define ROB_VALID     0
`define ROB_BUSY      1
`define ROB_EXCEPTION 2
`define ROB_ISSTORE   3
`define ROB_ECAUSE    8:4
`define ROB_PC        40:9
`define ROB_LEN       41
`endif

module retire_unit #(
  parameter int unsigned RETIRE_RATE   = 2,
  parameter int unsigned ROB_DEPTH     = 64,
  parameter int unsigned ROB_DEPTH_LEN = $clog2(ROB_DEPTH),
  parameter int unsigned ROB_LEN       = `ROB_LEN
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [RETIRE_RATE*ROB_LEN-1:0]     ROB_ReadData,
  input  logic [ROB_DEPTH_LEN:0]             ROB_UsedEntries,
  input  logic                               Hold_Retire,
  output logic [$clog2(RETIRE_RATE):0]       RetireCnt,
  output logic [RETIRE_RATE-1:0]             Retire_Valid,
  output logic                               StoreCommit_Req,
  input  logic                               StoreCommit_Ack,
  output logic                               Trap_Valid,
  output logic [`PC_LEN-1:0]                 Trap_PC,
  output logic [`ECAUSE_LEN-1:0]             Trap_Cause,
  input  logic                               Trap_Ack,
  output logic                               Flush,
  output logic [63:0]                        InstRet
);

  localparam int unsigned CNT_W = $clog2(RETIRE_RATE) + 1;
  localparam int unsigned USE_W = ROB_DEPTH_LEN + 1;

  typedef enum logic [1:0] {RUN, TRAP, FLUSH} state_t;

  state_t state, state_nxt;

  logic [ROB_LEN-1:0]     slot [RETIRE_RATE];
  logic [RETIRE_RATE-1:0] slot_ready;
  logic [RETIRE_RATE-1:0] slot_store;
  logic                   trap_take;
  logic                   chain;
  logic                   unused_fields;

  // Only slot 0's PC/cause are consumed; the remaining field bits are don't-care.
  assign unused_fields = ^ROB_ReadData;

  always_comb begin
    for (int unsigned i = 0; i < RETIRE_RATE; i++) begin
      slot[i]       = ROB_ReadData[i*ROB_LEN +: ROB_LEN];
      slot_ready[i] = (USE_W'(i) < ROB_UsedEntries) & slot[i][`ROB_VALID] &
                      ~slot[i][`ROB_BUSY] & ~slot[i][`ROB_EXCEPTION];
      slot_store[i] = slot[i][`ROB_ISSTORE];
    end
  end

  assign trap_take = slot[0][`ROB_VALID] & ~slot[0][`ROB_BUSY] &
                     slot[0][`ROB_EXCEPTION] & ~Hold_Retire;

  // Walk slots oldest-first; 'chain' stays high only while every older slot
  // retires. A store ends the chain whether or not the LSU accepts it, so at
  // most one store retires and nothing younger retires alongside it.
  always_comb begin
    RetireCnt       = '0;
    Retire_Valid    = '0;
    StoreCommit_Req = 1'b0;
    chain           = (state == RUN) & ~Hold_Retire & ~rst;
    for (int unsigned i = 0; i < RETIRE_RATE; i++) begin
      if (chain && slot_ready[i]) begin
        if (slot_store[i]) begin
          StoreCommit_Req = 1'b1;
          if (StoreCommit_Ack) begin
            Retire_Valid[i] = 1'b1;
            RetireCnt       = RetireCnt + CNT_W'(1);
          end
          chain = 1'b0;
        end else begin
          Retire_Valid[i] = 1'b1;
          RetireCnt       = RetireCnt + CNT_W'(1);
        end
      end else begin
        chain = 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (trap_take) state_nxt = TRAP;
      TRAP:    if (Trap_Ack)  state_nxt = FLUSH;
      FLUSH:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      Trap_PC    <= '0;
      Trap_Cause <= '0;
      InstRet    <= '0;
    end else begin
      state   <= state_nxt;
      InstRet <= InstRet + 64'(RetireCnt);
      if (state == RUN && trap_take) begin
        Trap_PC    <= slot[0][`ROB_PC];
        Trap_Cause <= slot[0][`ROB_ECAUSE];
      end
    end
  end

  assign Trap_Valid = (state == TRAP);
  assign Flush      = (state == FLUSH);

endmodule

// File: tb/tb_retire_unit.sv
// Directed testbench for retire_unit (RETIRE_RATE=2, ROB_DEPTH=64).

`ifndef PC_LEN
`define PC_LEN 32
`endif
`ifndef ECAUSE_LEN
`define ECAUSE_LEN 5
`endif
`ifndef ROB_LEN
`define ROB_VALID     0
`define ROB_BUSY      1
`define ROB_EXCEPTION 2
`define ROB_ISSTORE   3
`define ROB_ECAUSE    8:4
`define ROB_PC        40:9
`define ROB_LEN       41
`endif

module tb_retire_unit;

  localparam int unsigned RR = 2;
  localparam int unsigned RL = `ROB_LEN;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [RR*RL-1:0]      ROB_ReadData;
  logic [6:0]            ROB_UsedEntries;
  logic                  Hold_Retire;
  logic [1:0]            RetireCnt;
  logic [RR-1:0]         Retire_Valid;
  logic                  StoreCommit_Req;
  logic                  StoreCommit_Ack;
  logic                  Trap_Valid;
  logic [`PC_LEN-1:0]    Trap_PC;
  logic [`ECAUSE_LEN-1:0] Trap_Cause;
  logic                  Trap_Ack;
  logic                  Flush;
  logic [63:0]           InstRet;

  int tests = 0;
  int fails = 0;

  retire_unit #(.RETIRE_RATE(2), .ROB_DEPTH(64)) dut (
    .clk(clk), .rst(rst), .ROB_ReadData(ROB_ReadData),
    .ROB_UsedEntries(ROB_UsedEntries), .Hold_Retire(Hold_Retire),
    .RetireCnt(RetireCnt), .Retire_Valid(Retire_Valid),
    .StoreCommit_Req(StoreCommit_Req), .StoreCommit_Ack(StoreCommit_Ack),
    .Trap_Valid(Trap_Valid), .Trap_PC(Trap_PC), .Trap_Cause(Trap_Cause),
    .Trap_Ack(Trap_Ack), .Flush(Flush), .InstRet(InstRet)
  );

  always #5 clk = ~clk;

  function automatic logic [RL-1:0] mk(input logic v, input logic b,
                                        input logic e, input logic st,
                                        input logic [`ECAUSE_LEN-1:0] c,
                                        input logic [`PC_LEN-1:0] pc);
    logic [RL-1:0] r;
    r = '0;
    r[`ROB_VALID]     = v;
    r[`ROB_BUSY]      = b;
    r[`ROB_EXCEPTION] = e;
    r[`ROB_ISSTORE]   = st;
    r[`ROB_ECAUSE]    = c;
    r[`ROB_PC]        = pc;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [RL-1:0] s1, input logic [RL-1:0] s0,
                       input logic [6:0] used);
    ROB_ReadData    = {s1, s0};
    ROB_UsedEntries = used;
    #1;
  endtask

  logic [RL-1:0] rdy, bsy, st, exc2, nv;

  initial begin
    rdy  = mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    bsy  = mk(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    st   = mk(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0);
    exc2 = mk(1'b1, 1'b0, 1'b1, 1'b0, 5'd2, 32'h8000_0010);
    nv   = mk(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

    rst = 1'b1; Hold_Retire = 1'b0; StoreCommit_Ack = 1'b0; Trap_Ack = 1'b0;
    ROB_ReadData = {rdy, rdy}; ROB_UsedEntries = 7'd5;
    tick(); tick();
    chk("rst_cnt", 64'(RetireCnt), 64'd0);
    chk("rst_rv", 64'(Retire_Valid), 64'd0);
    chk("rst_req", 64'(StoreCommit_Req), 64'd0);
    chk("rst_trap", 64'(Trap_Valid), 64'd0);
    chk("rst_flush", 64'(Flush), 64'd0);
    chk("rst_instret", InstRet, 64'd0);
    chk("rst_tpc", 64'(Trap_PC), 64'd0);
    chk("rst_tcause", 64'(Trap_Cause), 64'd0);
    rst = 1'b0;

    // Two ready non-stores
    drive(rdy, rdy, 7'd5);
    chk("two_cnt", 64'(RetireCnt), 64'd2);
    chk("two_rv", 64'(Retire_Valid), 64'd3);
    chk("two_req", 64'(StoreCommit_Req), 64'd0);
    tick();
    chk("two_instret", InstRet, 64'd2);

    // Slot1 busy, then ready
    drive(bsy, rdy, 7'd5);
    chk("busy_cnt", 64'(RetireCnt), 64'd1);
    chk("busy_rv", 64'(Retire_Valid), 64'd1);
    tick();
    chk("busy_instret", InstRet, 64'd3);
    drive(rdy, rdy, 7'd4);
    chk("newhead_cnt", 64'(RetireCnt), 64'd2);
    tick();
    chk("newhead_instret", InstRet, 64'd5);

    // Store at slot 0, Ack withheld 3 cycles
    drive(rdy, st, 7'd5);
    for (int k = 0; k < 3; k++) begin
      chk("st_wait_req", 64'(StoreCommit_Req), 64'd1);
      chk("st_wait_cnt", 64'(RetireCnt), 64'd0);
      tick();
    end
    chk("st_wait_instret", InstRet, 64'd5);
    StoreCommit_Ack = 1'b1; #1;
    chk("st_ack_req", 64'(StoreCommit_Req), 64'd1);
    chk("st_ack_cnt", 64'(RetireCnt), 64'd1);
    chk("st_ack_rv", 64'(Retire_Valid), 64'd1);
    tick();
    chk("st_ack_instret", InstRet, 64'd6);

    // Store at slot 1 behind a ready op, Ack high
    drive(st, rdy, 7'd5);
    chk("st1_req", 64'(StoreCommit_Req), 64'd1);
    chk("st1_cnt", 64'(RetireCnt), 64'd2);
    tick();
    chk("st1_instret", InstRet, 64'd8);
    StoreCommit_Ack = 1'b0;

    // Exception at slot 1
    drive(exc2, rdy, 7'd5);
    chk("exc1_cnt", 64'(RetireCnt), 64'd1);
    chk("exc1_rv", 64'(Retire_Valid), 64'd1);
    tick();
    chk("exc1_instret", InstRet, 64'd9);
    chk("exc1_notrap", 64'(Trap_Valid), 64'd0);
    drive(rdy, exc2, 7'd4);
    chk("exc0_cnt", 64'(RetireCnt), 64'd0);
    tick();
    chk("trap_valid", 64'(Trap_Valid), 64'd1);
    chk("trap_pc", 64'(Trap_PC), 64'h8000_0010);
    chk("trap_cause", 64'(Trap_Cause), 64'd2);
    // Ready store at head must not retire or request while trapping
    drive(rdy, st, 7'd4);
    StoreCommit_Ack = 1'b1; #1;
    chk("trap_cnt", 64'(RetireCnt), 64'd0);
    chk("trap_req", 64'(StoreCommit_Req), 64'd0);
    tick();
    chk("trap_hold", 64'(Trap_Valid), 64'd1);
    chk("trap_noflush", 64'(Flush), 64'd0);
    tick();
    chk("trap_instret", InstRet, 64'd9);
    Trap_Ack = 1'b1; StoreCommit_Ack = 1'b0;
    tick();
    chk("flush_on", 64'(Flush), 64'd1);
    chk("flush_trapoff", 64'(Trap_Valid), 64'd0);
    chk("flush_cnt", 64'(RetireCnt), 64'd0);
    tick();
    chk("flush_off", 64'(Flush), 64'd0);
    chk("run_trapoff", 64'(Trap_Valid), 64'd0);
    chk("run_instret", InstRet, 64'd9);

    // Trap_Ack in RUN is ignored
    drive(rdy, rdy, 7'd5);
    chk("run_cnt", 64'(RetireCnt), 64'd2);
    tick();
    chk("ackrun_flush", 64'(Flush), 64'd0);
    chk("ackrun_instret", InstRet, 64'd11);
    Trap_Ack = 1'b0;

    // UsedEntries bound, empty ROB, Hold_Retire
    drive(rdy, rdy, 7'd1);
    chk("used1_cnt", 64'(RetireCnt), 64'd1);
    chk("used1_rv", 64'(Retire_Valid), 64'd1);
    drive(rdy, rdy, 7'd0);
    chk("empty_cnt", 64'(RetireCnt), 64'd0);
    drive(rdy, st, 7'd5);
    Hold_Retire = 1'b1; StoreCommit_Ack = 1'b1; #1;
    chk("hold_cnt", 64'(RetireCnt), 64'd0);
    chk("hold_req", 64'(StoreCommit_Req), 64'd0);
    tick();
    chk("hold_instret", InstRet, 64'd11);
    StoreCommit_Ack = 1'b0;
    drive(rdy, exc2, 7'd5);
    tick();
    chk("hold_notrap", 64'(Trap_Valid), 64'd0);
    Hold_Retire = 1'b0;
    drive(nv, rdy, 7'd5);
    chk("killed_cnt", 64'(RetireCnt), 64'd1);

    // Reset during TRAP
    drive(rdy, exc2, 7'd5);
    tick();
    chk("trap2_valid", 64'(Trap_Valid), 64'd1);
    rst = 1'b1;
    tick();
    chk("rsttrap_valid", 64'(Trap_Valid), 64'd0);
    chk("rsttrap_flush", 64'(Flush), 64'd0);
    chk("rsttrap_instret", InstRet, 64'd0);
    chk("rsttrap_tpc", 64'(Trap_PC), 64'd0);
    rst = 1'b0;
    drive(rdy, rdy, 7'd5);
    chk("rsttrap_run_cnt", 64'(RetireCnt), 64'd2);
    tick();
    chk("rsttrap_run_instret", InstRet, 64'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
